// File: rtl/regfile_scb.sv
// ============================================================================
// Module      : regfile_scb
// Description : Multi-port register file with write bypass and a per-register
//               busy scoreboard (set on issue, cleared on write or flush).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int NWP  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRP*AW-1:0]    raddr,
    output logic [NRP*XLEN-1:0]  rdata,
    output logic [NRP-1:0]       rbusy,
    input  logic [NWP-1:0]       we,
    input  logic [NWP*AW-1:0]    waddr,
    input  logic [NWP*XLEN-1:0]  wdata,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 flush,
    output logic [NREG*XLEN-1:0] regs_o,
    output logic [NREG-1:0]      busy_o
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic [NWP-1:0]  w_we;
    logic [NREG-1:0] w_wr_hit;
    logic [XLEN-1:0] w_wr_val [NREG];
    logic [XLEN-1:0] w_bypass [NREG];
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_busy_nxt;

    // Writes are suppressed while in reset so the bypass path also reads zero.
    assign w_we = we & {NWP{rst_n}};

    // Ascending scan: a later (higher-index) port overrides earlier ones.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_wr_hit[r] = 1'b0;
            w_wr_val[r] = '0;
        end
        for (int w = 0; w < NWP; w++) begin
            if (w_we[w]) begin
                w_wr_hit[waddr[w*AW +: AW]] = 1'b1;
                w_wr_val[waddr[w*AW +: AW]] = wdata[w*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
                w_bypass[r] = '0;
            end else if (w_wr_hit[r]) begin
                w_bypass[r] = w_wr_val[r];
            end else begin
                w_bypass[r] = r_regs[r];
            end
        end
    end

    // Issue set beats a same-cycle write clear; flush beats everything.
    assign w_set      = {NREG{iss_valid}} & (NREG'(1) << iss_rd) & ~NREG'(1);
    assign w_busy_nxt = flush ? '0 : ((r_busy & ~w_wr_hit) | w_set);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_wr_hit[r]) begin
                    r_regs[r] <= w_wr_val[r];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    generate
        for (genvar p = 0; p < NRP; p++) begin : g_rd
            assign rdata[p*XLEN +: XLEN] = w_bypass[raddr[p*AW +: AW]];
            assign rbusy[p] = r_busy[raddr[p*AW +: AW]] & ~w_wr_hit[raddr[p*AW +: AW]];
        end
        for (genvar i = 0; i < NREG; i++) begin : g_out
            assign regs_o[i*XLEN +: XLEN] = w_bypass[i];
        end
    endgenerate

    assign busy_o = r_busy;

endmodule

`default_nettype wire

// File: doc/regfile_scb.md
REGFILE_SCB -- requirements
Module: regfile_scb

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the number of architectural registers (power of two, at least 2).
REQ-003 The block SHALL have parameter NRP, default 2, meaning the number of read ports.
REQ-004 The block SHALL have parameter NWP, default 2, meaning the number of write ports.
REQ-005 The block SHALL have derived localparam AW = $clog2(NREG), meaning the register address width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port raddr, input, NRP*AW bits: read address, port p at [p*AW +: AW].
REQ-009 The block SHALL have port rdata, output, NRP*XLEN bits: read data, port p at [p*XLEN +: XLEN].
REQ-010 The block SHALL have port rbusy, output, NRP bits: pending-write flag per read port.
REQ-011 The block SHALL have port we, input, NWP bits: write enable per write port.
REQ-012 The block SHALL have port waddr, input, NWP*AW bits: write address per write port.
REQ-013 The block SHALL have port wdata, input, NWP*XLEN bits: write data per write port.
REQ-014 The block SHALL have port iss_valid, input, 1 bit: an instruction with a destination register is issued this cycle.
REQ-015 The block SHALL have port iss_rd, input, AW bits: destination register of the issued instruction.
REQ-016 The block SHALL have port flush, input, 1 bit: discard all pending writes.
REQ-017 The block SHALL have port regs_o, output, NREG*XLEN bits: architectural state for difftest, register i at [i*XLEN +: XLEN].
REQ-018 The block SHALL have port busy_o, output, NREG bits: scoreboard state.

Function
REQ-019 Register 0 SHALL read as zero on every port, SHALL never be written, and SHALL never be busy.
REQ-020 On a rising edge, each write port w with we[w]=1 and waddr≠0 SHALL update that register with wdata[w].
REQ-021 If several enabled write ports target the same register in one cycle, the highest-index port SHALL win, for both the stored value and bypass.
REQ-022 rdata for each port SHALL be combinational: 0 if raddr=0; otherwise the wdata of the winning same-cycle write to raddr if one exists; otherwise the stored value.
REQ-023 regs_o[i] SHALL apply the same bypass as REQ-022, so it shows the post-edge value of every register.
REQ-024 The scoreboard SHALL hold one busy bit per register. At each edge, busy[r] SHALL be set if iss_valid=1, iss_rd=r and r≠0, and cleared if any enabled write targets r.
REQ-025 If a set and a clear hit the same register in the same cycle, set SHALL win: the register stays busy.
REQ-026 Issue to a register that is already busy SHALL be legal; the bit stays set and the first subsequent write clears it. There is no producer counting.
REQ-027 When flush=1, all busy bits SHALL be cleared at the edge; flush SHALL take priority over a same-cycle issue. Register writes in that cycle SHALL still occur.
REQ-028 rbusy[p] SHALL equal busy[raddr_p] AND NOT (a same-cycle enabled write to raddr_p), and SHALL be 0 when raddr_p=0.
REQ-029 busy_o SHALL show the registered busy bits with no bypass.
REQ-030 Read-to-data latency SHALL be 0 cycles. Write-to-stored latency SHALL be 1 edge. Issue-to-busy latency SHALL be 1 edge.

Reset
REQ-031 When rst_n=0, all registers and all busy bits SHALL clear to 0 immediately, independent of clk.
REQ-032 While in reset, the outputs SHALL be: rdata=0, rbusy=0, regs_o=0, busy_o=0. we, iss_valid and flush SHALL be ignored.
REQ-033 Reset SHALL deassert synchronously to the design's use, and the first edge after deassertion SHALL be a normal operating edge.

Verification
REQ-034 Bench scenario, write and bypass: write x5=0xDEAD_BEEF on port 0 with raddr0=5 in the same cycle → rdata0=0xDEAD_BEEF in that cycle and after the edge.
REQ-035 Bench scenario, x0 is constant: we[0]=1, waddr=0, wdata=0x1234 → rdata=0 and regs_o[0]=0, with busy_o[0] never set even when iss_rd=0.
REQ-036 Bench scenario, write conflict: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle → x7=0x22 and bypass shows 0x22.
REQ-037 Bench scenario, scoreboard: issue x3 → busy_o[3]=1 on the next cycle; write x3 → rbusy=0 in the write cycle and busy_o[3]=0 after the edge; issue x3 together with a write to x3 → busy_o[3] stays 1.
REQ-038 Bench scenario, flush: busy x4 and x9, then flush plus issue x12 → busy_o=0 after the edge.
REQ-039 Bench scenario, async reset: drop rst_n mid-cycle with x10=0x55 and x10 busy → regs_o and busy_o read 0 before the next clk edge.
